// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - requester ports and controller-side bus of the two-port SDRAM arbiter
// slave is the arbiter side; master is the requesters plus controller side.
interface sdram_arbiter_if #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 8
);
  logic                  p0_req;
  logic                  p0_we;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_ack;
  logic                  p0_done;
  logic                  p0_err;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic                  p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_ack;
  logic                  p1_done;
  logic                  p1_err;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic [ADDR_WIDTH-1:0] sd_addr;
  logic [DATA_WIDTH-1:0] sd_wr_data;
  logic                  sd_wr_enable;
  logic                  sd_rd_enable;
  logic [DATA_WIDTH-1:0] sd_rd_data;
  logic                  sd_rd_ready;
  logic                  sd_busy;
  logic                  sd_ack;
  logic                  arb_busy;
  logic                  owner;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_done, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_done, p1_err, p1_rdata,
    output sd_addr, sd_wr_data, sd_wr_enable, sd_rd_enable,
    input  sd_rd_data, sd_rd_ready, sd_busy, sd_ack,
    output arb_busy, owner
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_done, p0_err, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_done, p1_err, p1_rdata,
    input  sd_addr, sd_wr_data, sd_wr_enable, sd_rd_enable,
    output sd_rd_data, sd_rd_ready, sd_busy, sd_ack,
    input  arb_busy, owner
  );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port round-robin arbiter in front of the sdram controller
// One transaction in flight; a cycle timer aborts anything the controller never finishes.
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1023
) (
  input logic           clk,
  input logic           rst,
  sdram_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR} state_t;

  state_t                state, state_n;
  logic [TW-1:0]         timer, timer_n;
  logic                  last_grant, last_grant_n;
  logic                  owner_q, owner_n;
  logic                  busy_q, busy_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic                  wr_en_q, wr_en_n;
  logic                  rd_en_q, rd_en_n;
  logic [1:0]            ack_q, ack_n;
  logic [1:0]            done_q, done_n;
  logic [1:0]            err_q, err_n;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_n;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_n;
  logic                  sel;
  logic                  sel_we;
  logic                  timed_out;

  // A tie goes to the port that did not win last time.
  assign sel       = (bus.p0_req && bus.p1_req) ? ~last_grant : bus.p1_req;
  assign sel_we    = sel ? bus.p1_we : bus.p0_we;
  assign timed_out = (timer == TIMER_MAX);

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    last_grant_n = last_grant;
    owner_n      = owner_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    wr_en_n      = wr_en_q;
    rd_en_n      = rd_en_q;
    ack_n        = 2'b00;
    done_n       = 2'b00;
    err_n        = 2'b00;
    rdata0_n     = rdata0_q;
    rdata1_n     = rdata1_q;

    case (state)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          state_n      = ISSUE;
          owner_n      = sel;
          last_grant_n = sel;
          ack_n[sel]   = 1'b1;
          addr_n       = sel ? bus.p1_addr : bus.p0_addr;
          wdata_n      = sel ? bus.p1_wdata : bus.p0_wdata;
          wr_en_n      = sel_we;
          rd_en_n      = ~sel_we;
          timer_n      = '0;
        end
      end
      ISSUE: begin
        timer_n = timer + TW'(1);
        if (bus.sd_ack) begin
          // A read-ready arriving with the ack is ignored; data follows later.
          wr_en_n = 1'b0;
          rd_en_n = 1'b0;
          timer_n = '0;
          state_n = rd_en_q ? WAIT_RD : WAIT_WR;
        end else if (timed_out) begin
          wr_en_n        = 1'b0;
          rd_en_n        = 1'b0;
          done_n[owner_q] = 1'b1;
          err_n[owner_q]  = 1'b1;
          state_n        = IDLE;
        end
      end
      WAIT_RD, WAIT_WR: begin
        timer_n = timer + TW'(1);
        if ((state == WAIT_RD) ? bus.sd_rd_ready : ~bus.sd_busy) begin
          done_n[owner_q] = 1'b1;
          if (state == WAIT_RD) begin
            if (owner_q) rdata1_n = bus.sd_rd_data;
            else         rdata0_n = bus.sd_rd_data;
          end
          state_n = IDLE;
        end else if (timed_out) begin
          done_n[owner_q] = 1'b1;
          err_n[owner_q]  = 1'b1;
          state_n        = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      ack_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      last_grant <= last_grant_n;
      owner_q    <= owner_n;
      busy_q     <= busy_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      wr_en_q    <= wr_en_n;
      rd_en_q    <= rd_en_n;
      ack_q      <= ack_n;
      done_q     <= done_n;
      err_q      <= err_n;
      rdata0_q   <= rdata0_n;
      rdata1_q   <= rdata1_n;
    end
  end

  assign bus.p0_ack       = ack_q[0];
  assign bus.p1_ack       = ack_q[1];
  assign bus.p0_done      = done_q[0];
  assign bus.p1_done      = done_q[1];
  assign bus.p0_err       = err_q[0];
  assign bus.p1_err       = err_q[1];
  assign bus.p0_rdata     = rdata0_q;
  assign bus.p1_rdata     = rdata1_q;
  assign bus.sd_addr      = addr_q;
  assign bus.sd_wr_data   = wdata_q;
  assign bus.sd_wr_enable = wr_en_q;
  assign bus.sd_rd_enable = rd_en_q;
  assign bus.arb_busy     = busy_q;
  assign bus.owner        = owner_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter
// Requesters, a controller model and a transaction-level expectation model run once per negedge.
module tb_sdram_arbiter;
  localparam int AW = 25;
  localparam int DW = 8;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  logic grants[$];
  int   checks = 0;
  int   errors = 0;

  // expectation model: one outstanding transaction and its cycle age
  logic          mdl_idle, mdl_busy, mdl_last, mdl_own, mdl_we, mdl_acked;
  int            mdl_cyc;
  logic [DW-1:0] mdl_rdata [2];
  logic          done_pend;
  logic [DW-1:0] done_val;

  // controller model knobs and state
  int            ack_dly, rd_dly, busy_len;
  logic          never_ack, ack_with_ready, rand_mode;
  logic [DW-1:0] rd_val;
  int            ctl_phase, ctl_cnt;
  logic          ctl_is_rd, ctl_ack_sent;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
    bus.sd_ack = 0; bus.sd_rd_ready = 0; bus.sd_busy = 0; bus.sd_rd_data = '0;
    q0.delete(); q1.delete();
    mdl_idle = 1; mdl_busy = 0; mdl_last = 1; mdl_own = 0; mdl_we = 0; mdl_acked = 0;
    mdl_cyc = 0; mdl_rdata[0] = '0; mdl_rdata[1] = '0; done_pend = 0; done_val = '0;
    ctl_phase = 0; ctl_cnt = 0; ctl_is_rd = 0; ctl_ack_sent = 0;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = AW'($urandom);
    t.wdata = DW'($urandom);
    return t;
  endfunction

  task automatic tick();
    logic r0, r1, sel, exp_ack, exp_done, exp_err, timeout, nwe;
    logic [AW-1:0] naddr;
    logic [DW-1:0] nwd;
    txn_t t;
    @(negedge clk);
    if (rst) begin
      model_reset();
      return;
    end
    // expectations for the edge just past
    if (ctl_ack_sent) begin mdl_acked = 1; ctl_ack_sent = 0; end
    if (mdl_busy) mdl_cyc++;
    timeout  = mdl_busy && !done_pend && (mdl_cyc == TO + 1);
    exp_done = done_pend || timeout;
    exp_err  = timeout;
    if (done_pend && !mdl_we) mdl_rdata[mdl_own] = done_val;
    r0 = bus.p0_req;
    r1 = bus.p1_req;
    exp_ack = mdl_idle && (r0 || r1);
    sel   = (r0 && r1) ? !mdl_last : r1;
    nwe   = sel ? bus.p1_we : bus.p0_we;
    naddr = sel ? bus.p1_addr : bus.p0_addr;
    nwd   = sel ? bus.p1_wdata : bus.p0_wdata;
    chk("p0_ack", bus.p0_ack, exp_ack && !sel);
    chk("p1_ack", bus.p1_ack, exp_ack && sel);
    chk("p0_done", bus.p0_done, exp_done && !mdl_own);
    chk("p1_done", bus.p1_done, exp_done && mdl_own);
    chk("p0_err", bus.p0_err, exp_err && !mdl_own);
    chk("p1_err", bus.p1_err, exp_err && mdl_own);
    chk("p0_rdata", bus.p0_rdata, mdl_rdata[0]);
    chk("p1_rdata", bus.p1_rdata, mdl_rdata[1]);
    if (exp_done) begin mdl_busy = 0; mdl_idle = 1; done_pend = 0; end
    if (exp_ack) begin
      mdl_busy = 1; mdl_idle = 0; mdl_own = sel; mdl_last = sel; mdl_we = nwe;
      mdl_acked = 0; mdl_cyc = 0;
      grants.push_back(sel);
      chk("sd_addr", bus.sd_addr, naddr);
      chk("sd_wr_data", bus.sd_wr_data, nwd);
    end
    chk("owner", bus.owner, mdl_own);
    chk("arb_busy", bus.arb_busy, mdl_busy);
    chk("sd_rd_enable", bus.sd_rd_enable, mdl_busy && !mdl_acked && !mdl_we);
    chk("sd_wr_enable", bus.sd_wr_enable, mdl_busy && !mdl_acked && mdl_we);

    // requesters: hold until ack, then present the next queued transaction
    if (bus.p0_ack && q0.size() > 0) begin t = q0.pop_front(); bus.p0_req = 0; end
    if (bus.p1_ack && q1.size() > 0) begin t = q1.pop_front(); bus.p1_req = 0; end
    if (!bus.p0_req && q0.size() > 0) begin
      bus.p0_req = 1; bus.p0_we = q0[0].we; bus.p0_addr = q0[0].addr; bus.p0_wdata = q0[0].wdata;
    end
    if (!bus.p1_req && q1.size() > 0) begin
      bus.p1_req = 1; bus.p1_we = q1[0].we; bus.p1_addr = q1[0].addr; bus.p1_wdata = q1[0].wdata;
    end

    // controller model
    bus.sd_ack = 0;
    bus.sd_rd_ready = 0;
    if (ctl_phase == 0 && (bus.sd_rd_enable || bus.sd_wr_enable) && !never_ack) begin
      ctl_is_rd = bus.sd_rd_enable;
      ctl_cnt   = 0;
      ctl_phase = 1;
      if (rand_mode) begin
        ack_dly  = $urandom_range(0, 3);
        rd_dly   = $urandom_range(1, 5);
        busy_len = $urandom_range(1, 6);
      end
    end
    if (ctl_phase == 1) begin
      if (ctl_cnt == ack_dly) begin
        bus.sd_ack = 1;
        ctl_ack_sent = 1;
        mdl_cyc = -1;
        if (ctl_is_rd && ack_with_ready) begin
          bus.sd_rd_ready = 1;
          bus.sd_rd_data  = 8'hEE;
        end
        if (!ctl_is_rd) begin bus.sd_busy = 1; ctl_cnt = 1; end
        else ctl_cnt = 0;
        ctl_phase = 2;
      end else ctl_cnt++;
    end else if (ctl_phase == 2) begin
      if (ctl_is_rd) begin
        ctl_cnt++;
        if (ctl_cnt == rd_dly) begin
          bus.sd_rd_ready = 1;
          bus.sd_rd_data  = rand_mode ? DW'($urandom) : rd_val;
          done_val  = bus.sd_rd_data;
          done_pend = 1;
          ctl_phase = 0;
        end
      end else if (ctl_cnt == busy_len) begin
        bus.sd_busy = 0;
        done_pend = 1;
        ctl_phase = 0;
      end else ctl_cnt++;
    end
  endtask

  task automatic wait_idle(input int bound);
    logic ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!mdl_busy && q0.size() == 0 && q1.size() == 0 && !bus.p0_req && !bus.p1_req) begin
        ok = 1;
        break;
      end
    end
    chk("wait_idle", ok, 1);
  endtask

  initial begin
    txn_t t;
    logic start;
    logic [DW-1:0] saved;
    logic reached;
    model_reset();
    never_ack = 0; ack_with_ready = 0; rand_mode = 0;
    ack_dly = 0; rd_dly = 1; busy_len = 1; rd_val = '0;

    // reset state
    tick(); tick();
    chk("rst_ack", {bus.p0_ack, bus.p1_ack, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err}, 0);
    chk("rst_en", {bus.sd_rd_enable, bus.sd_wr_enable, bus.arb_busy, bus.owner}, 0);
    chk("rst_rdata", {bus.p0_rdata, bus.p1_rdata}, 0);
    chk("rst_sd", {bus.sd_addr, bus.sd_wr_data}, 0);
    rst = 0;
    tick();

    // port 0 read, data 4 cycles after ack
    ack_dly = 2; rd_dly = 4; rd_val = 8'h5A;
    t.we = 0; t.addr = 25'h0000123; t.wdata = 8'h00; q0.push_back(t);
    wait_idle(60);
    chk("t1_rdata", bus.p0_rdata, 8'h5A);

    // port 1 write at the top address, busy for 6 cycles
    ack_dly = 1; busy_len = 6;
    t.we = 1; t.addr = 25'h1FFFFFF; t.wdata = 8'hC3; q1.push_back(t);
    wait_idle(60);

    // both ports continuously requesting
    rand_mode = 1;
    for (int i = 0; i < 4; i++) begin q0.push_back(rand_txn()); q1.push_back(rand_txn()); end
    grants.delete();
    start = !mdl_last;
    wait_idle(400);
    chk("fair_count", grants.size(), 8);
    for (int i = 0; i < grants.size() && i < 8; i++) chk("fair_order", grants[i], start ^ 1'(i));
    chk("fair_first", start, 0);

    // controller never acks
    rand_mode = 0; never_ack = 1;
    saved = mdl_rdata[0];
    t.we = 0; t.addr = 25'h0ABCDE; t.wdata = 8'h11; q0.push_back(t);
    wait_idle(60);
    chk("to_rdata_kept", bus.p0_rdata, saved);
    never_ack = 0;

    // ack and rd_ready together, real data two cycles later
    ack_with_ready = 1; ack_dly = 0; rd_dly = 2; rd_val = 8'hA5;
    t.we = 0; t.addr = 25'h0000777; t.wdata = 8'h00; q1.push_back(t);
    wait_idle(60);
    chk("awr_rdata", bus.p1_rdata, 8'hA5);
    ack_with_ready = 0;

    // random mix
    rand_mode = 1;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) q0.push_back(rand_txn());
      else q1.push_back(rand_txn());
      repeat ($urandom_range(0, 6)) tick();
    end
    wait_idle(1500);

    // reset in the middle of WAIT_RD
    rand_mode = 0; ack_dly = 0; rd_dly = 10; rd_val = 8'h3C;
    t.we = 0; t.addr = 25'h0000042; t.wdata = 8'h00; q1.push_back(t);
    reached = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mdl_busy && mdl_acked) begin reached = 1; break; end
    end
    chk("reach_wait_rd", reached, 1);
    tick(); tick();
    #2 rst = 1;
    #1;
    chk("arst_en", {bus.sd_rd_enable, bus.sd_wr_enable, bus.arb_busy}, 0);
    chk("arst_pulses", {bus.p0_ack, bus.p1_ack, bus.p0_done, bus.p1_done}, 0);
    model_reset();
    tick(); tick();
    rst = 0;
    tick();
    grants.delete();
    ack_dly = 0; rd_dly = 1; rd_val = 8'h77;
    t.we = 0; t.addr = 25'h0000100; q0.push_back(t);
    t.addr = 25'h0000200; q1.push_back(t);
    wait_idle(60);
    chk("post_rst_grants", grants.size(), 2);
    if (grants.size() > 0) chk("post_rst_tie", grants[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
